// File: rtl/st7735_spi_rx.sv
// st7735_spi_rx: oversampling ST7735 4-wire SPI receiver; decodes window/RAMWR/power commands into tagged RGB565 pixels.
// Optional sticky protocol-error detection is built when ST7735_RX_PROTO_ERR_EN is defined.
module st7735_spi_rx #(
  parameter int COORD_W = 8,
  parameter int DEF_XE  = 127,
  parameter int DEF_YE  = 159
) (
  input  logic               SYSTEM_CLK,
  input  logic               RESET_N,
  input  logic               CS,
  input  logic               DC,
  input  logic               LCD_CLK,
  input  logic               MOSI,
  input  logic               LCD_RESET_N,
  output logic               BYTE_VALID,
  output logic [7:0]         BYTE,
  output logic               BYTE_DC,
  output logic               PIX_VALID,
  output logic [COORD_W-1:0] PIX_X,
  output logic [COORD_W-1:0] PIX_Y,
  output logic [15:0]        PIX_DATA,
  output logic               DISP_ON,
  output logic               SLEEP_OUT,
  output logic               PROTO_ERR
);
  typedef enum logic [2:0] {IDLE, CASET, RASET, RAMWR, SKIP} state_t;
  logic [1:0] cs_q, dc_q, clk_q, mosi_q, lrst_q;
  logic clk_d, rst, rise, pend, pend_dc, ph;
  logic [2:0] cnt;
  logic [7:0] sh, arg_hi, pix_hi;
  logic [1:0] idx;
  logic [COORD_W-1:0] xs, xe, ys, ye, px, py, st, val;
  state_t state;
  // Sync flops follow only the system reset so a panel reset does not stretch itself.
  always_ff @(posedge SYSTEM_CLK)
    if (!RESET_N) begin
      cs_q   <= 2'b11;
      dc_q   <= 2'b00;
      clk_q  <= 2'b00;
      mosi_q <= 2'b00;
      lrst_q <= 2'b11;
    end else begin
      cs_q   <= {cs_q[0], CS};
      dc_q   <= {dc_q[0], DC};
      clk_q  <= {clk_q[0], LCD_CLK};
      mosi_q <= {mosi_q[0], MOSI};
      lrst_q <= {lrst_q[0], LCD_RESET_N};
    end
  assign rst  = !RESET_N || !lrst_q[1];
  assign rise = clk_q[1] && !clk_d;
  assign val  = COORD_W'({arg_hi, BYTE});
  always_ff @(posedge SYSTEM_CLK)
    if (rst) begin
      clk_d      <= 1'b0;
      cnt        <= 3'd0;
      sh         <= 8'd0;
      pend       <= 1'b0;
      pend_dc    <= 1'b0;
      BYTE_VALID <= 1'b0;
      BYTE       <= 8'd0;
      BYTE_DC    <= 1'b0;
    end else begin
      clk_d      <= clk_q[1];
      BYTE_VALID <= pend;
      pend       <= 1'b0;
      if (pend) begin
        BYTE    <= sh;
        BYTE_DC <= pend_dc;
      end
      if (cs_q[1]) cnt <= 3'd0;
      else if (rise) begin
        sh  <= {sh[6:0], mosi_q[1]};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          pend    <= 1'b1;
          pend_dc <= dc_q[1];
        end
      end
    end
  always_ff @(posedge SYSTEM_CLK)
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      arg_hi    <= 8'd0;
      st        <= '0;
      xs        <= '0;
      xe        <= COORD_W'(DEF_XE);
      ys        <= '0;
      ye        <= COORD_W'(DEF_YE);
      px        <= '0;
      py        <= '0;
      ph        <= 1'b0;
      pix_hi    <= 8'd0;
      PIX_VALID <= 1'b0;
      PIX_X     <= '0;
      PIX_Y     <= '0;
      PIX_DATA  <= 16'd0;
      DISP_ON   <= 1'b0;
      SLEEP_OUT <= 1'b0;
    end else begin
      PIX_VALID <= 1'b0;
      if (BYTE_VALID) begin
        if (!BYTE_DC) begin
          idx   <= 2'd0;
          state <= BYTE == 8'h2A ? CASET :
                   BYTE == 8'h2B ? RASET :
                   BYTE == 8'h2C ? RAMWR :
                   (BYTE == 8'h01 || BYTE == 8'h11 || BYTE == 8'h29 || BYTE == 8'h28) ? IDLE : SKIP;
          if (BYTE == 8'h2C) begin
            px <= xs;
            py <= ys;
            ph <= 1'b0;
          end
          if (BYTE == 8'h01) begin
            xs        <= '0;
            xe        <= COORD_W'(DEF_XE);
            ys        <= '0;
            ye        <= COORD_W'(DEF_YE);
            DISP_ON   <= 1'b0;
            SLEEP_OUT <= 1'b0;
          end
          if (BYTE == 8'h11) SLEEP_OUT <= 1'b1;
          if (BYTE == 8'h29) DISP_ON <= 1'b1;
          if (BYTE == 8'h28) DISP_ON <= 1'b0;
        end else if (state == CASET || state == RASET) begin
          idx <= idx + 2'd1;
          if (!idx[0]) arg_hi <= BYTE;
          if (idx == 2'd1) st <= val;
          if (idx == 2'd3) begin
            if (state == CASET) begin
              xs <= st;
              xe <= val;
            end else begin
              ys <= st;
              ye <= val;
            end
            state <= SKIP;
          end
        end else if (state == RAMWR) begin
          ph <= !ph;
          if (!ph) pix_hi <= BYTE;
          else begin
            PIX_VALID <= 1'b1;
            PIX_DATA  <= {pix_hi, BYTE};
            PIX_X     <= px;
            PIX_Y     <= py;
            // Raster walk inside the window; wraps only on exact equality with the end.
            if (px == xe) begin
              px <= xs;
              py <= (py == ye) ? ys : py + COORD_W'(1);
            end else px <= px + COORD_W'(1);
          end
        end
      end
    end
`ifdef ST7735_RX_PROTO_ERR_EN
  always_ff @(posedge SYSTEM_CLK)
    if (rst) PROTO_ERR <= 1'b0;
    else if ((cs_q[1] && cnt != 3'd0) ||
             (BYTE_VALID && BYTE_DC && state == IDLE) ||
             (BYTE_VALID && !BYTE_DC && (state == CASET || state == RASET) && idx != 2'd0) ||
             (BYTE_VALID && !BYTE_DC && state == RAMWR && ph))
      PROTO_ERR <= 1'b1;
`else
  assign PROTO_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_st7735_spi_rx.sv
// tb_st7735_spi_rx: table-driven and randomized bench for st7735_spi_rx against a window/raster reference model.
module tb_st7735_spi_rx;
`ifdef ST7735_RX_PROTO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic RESET_N, CS, DC, LCD_CLK, MOSI, LCD_RESET_N;
  logic BYTE_VALID, BYTE_DC, PIX_VALID, DISP_ON, SLEEP_OUT, PROTO_ERR;
  logic [7:0] BYTE, PIX_X, PIX_Y;
  logic [15:0] PIX_DATA;
  int n_pass = 0, n_total = 0, lat;
  logic [8:0] got_b[$], exp_b[$];
  logic [31:0] got_p[$], exp_p[$];
  int m_mode, m_xs, m_xe, m_ys, m_ye, m_n;
  bit m_half, m_disp, m_slp, m_err;
  logic [7:0] m_hb;
  logic [7:0] m_args[$];
  typedef struct { bit dc; logic [7:0] b; bit disp; bit slp; } vec_t;
  vec_t tbl[8];

  st7735_spi_rx dut (
    .SYSTEM_CLK(clk), .RESET_N(RESET_N), .CS(CS), .DC(DC), .LCD_CLK(LCD_CLK), .MOSI(MOSI),
    .LCD_RESET_N(LCD_RESET_N), .BYTE_VALID(BYTE_VALID), .BYTE(BYTE), .BYTE_DC(BYTE_DC),
    .PIX_VALID(PIX_VALID), .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_DATA(PIX_DATA),
    .DISP_ON(DISP_ON), .SLEEP_OUT(SLEEP_OUT), .PROTO_ERR(PROTO_ERR)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (BYTE_VALID) got_b.push_back({BYTE_DC, BYTE});
    if (PIX_VALID) got_p.push_back({PIX_X, PIX_Y, PIX_DATA});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic m_reset();
    m_xs = 0; m_xe = 127; m_ys = 0; m_ye = 159;
    m_disp = 0; m_slp = 0; m_err = 0; m_mode = 0; m_half = 0; m_n = 0;
    m_args.delete();
  endtask

  // Reference: pixel n of a RAMWR burst lands at raster position n inside the window rectangle.
  task automatic m_byte(input bit dc, input logic [7:0] b);
    int w, h;
    if (!dc) begin
      if (((m_mode == 1 || m_mode == 2) && m_args.size() > 0) || (m_mode == 3 && m_half)) m_err = 1;
      m_args.delete();
      m_half = 0;
      case (b)
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin m_mode = 3; m_n = 0; end
        8'h01: begin m_mode = 0; m_xs = 0; m_xe = 127; m_ys = 0; m_ye = 159; m_disp = 0; m_slp = 0; end
        8'h11: begin m_mode = 0; m_slp = 1; end
        8'h29: begin m_mode = 0; m_disp = 1; end
        8'h28: begin m_mode = 0; m_disp = 0; end
        default: m_mode = 4;
      endcase
    end else if (m_mode == 0) m_err = 1;
    else if (m_mode == 1 || m_mode == 2) begin
      m_args.push_back(b);
      if (m_args.size() == 4) begin
        if (m_mode == 1) begin m_xs = m_args[1]; m_xe = m_args[3]; end
        else begin m_ys = m_args[1]; m_ye = m_args[3]; end
        m_mode = 4;
      end
    end else if (m_mode == 3) begin
      if (!m_half) begin m_hb = b; m_half = 1; end
      else begin
        w = m_xe - m_xs + 1;
        h = m_ye - m_ys + 1;
        exp_p.push_back({8'(m_xs + m_n % w), 8'(m_ys + (m_n / w) % h), m_hb, b});
        m_n++;
        m_half = 0;
      end
    end
  endtask

  task automatic send_bit(input bit dc, input bit v, input bit last);
    DC = dc; MOSI = v;
    repeat (4) @(negedge clk);
    LCD_CLK = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (last && BYTE_VALID && lat == 0) lat = k;
    end
    LCD_CLK = 1'b0;
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b);
    CS = 1'b0; lat = 0;
    for (int i = 7; i >= 0; i--) send_bit(dc, b[i], i == 0);
    repeat (2) @(negedge clk);
    m_byte(dc, b);
    exp_b.push_back({dc, b});
  endtask

  task automatic send_cmd4(input logic [7:0] c, input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] a2, input logic [7:0] a3);
    send_byte(0, c); send_byte(1, a0); send_byte(1, a1); send_byte(1, a2); send_byte(1, a3);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_byte_count"}, got_b.size(), exp_b.size());
    while (got_b.size() > 0 && exp_b.size() > 0) chk({tag, "_byte"}, got_b.pop_front(), exp_b.pop_front());
    got_b.delete(); exp_b.delete();
    chk({tag, "_pix_count"}, got_p.size(), exp_p.size());
    while (got_p.size() > 0 && exp_p.size() > 0) chk({tag, "_pix"}, got_p.pop_front(), exp_p.pop_front());
    got_p.delete(); exp_p.delete();
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_disp_on"}, DISP_ON, m_disp);
    chk({tag, "_sleep_out"}, SLEEP_OUT, m_slp);
    chk({tag, "_proto_err"}, PROTO_ERR, ERR_EN & m_err);
  endtask

  initial begin
    logic [7:0] xs, xe, ys, ye, c;
    int np;
    tbl[0] = '{0, 8'h28, 0, 0};
    tbl[1] = '{0, 8'h11, 0, 1};
    tbl[2] = '{0, 8'h29, 1, 1};
    tbl[3] = '{0, 8'h01, 0, 0};
    tbl[4] = '{0, 8'h29, 1, 0};
    tbl[5] = '{0, 8'h42, 1, 0};
    tbl[6] = '{1, 8'h3C, 1, 0};
    tbl[7] = '{0, 8'h28, 0, 0};
    RESET_N = 0; CS = 1; DC = 0; LCD_CLK = 0; MOSI = 0; LCD_RESET_N = 1;
    m_reset();
    repeat (5) @(negedge clk);
    chk("reset_outputs", {BYTE_VALID, BYTE, BYTE_DC, PIX_VALID, PIX_X, PIX_Y, PIX_DATA, DISP_ON, SLEEP_OUT, PROTO_ERR}, 64'd0);
    RESET_N = 1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", {BYTE_VALID, PIX_VALID, DISP_ON, SLEEP_OUT, PROTO_ERR}, 64'd0);
    // DISPON with latency measured from the first sampled high level of the 8th clock.
    send_byte(0, 8'h29);
    chk("byte_latency", lat, 4);
    chk("dispon_byte", {BYTE_DC, BYTE}, 9'h029);
    check_flags("dispon");
    check_stream("dispon");
    for (int i = 0; i < 8; i++) begin
      send_byte(tbl[i].dc, tbl[i].b);
      chk($sformatf("tbl%0d_byte", i), {BYTE_DC, BYTE}, {tbl[i].dc, tbl[i].b});
      chk($sformatf("tbl%0d_flags", i), {DISP_ON, SLEEP_OUT}, {tbl[i].disp, tbl[i].slp});
    end
    check_stream("table");
    // Window 2..5 x 10..11 with nine pixels: the ninth wraps back to the origin.
    send_cmd4(8'h2A, 8'h00, 8'h02, 8'h00, 8'h05);
    send_cmd4(8'h2B, 8'h00, 8'h0A, 8'h00, 8'h0B);
    send_byte(0, 8'h2C);
    for (int i = 0; i < 18; i++) send_byte(1, 8'($urandom));
    chk("ninth_pixel_xy", got_p.size() >= 9 ? {32'd0, got_p[8][31:16]} : 64'hx, 64'h020A);
    chk("first_pixel_xy", got_p.size() >= 1 ? {32'd0, got_p[0][31:16]} : 64'hx, 64'h020A);
    check_stream("window");
    check_flags("window");
    // Partial byte dropped by CS rising after 5 bits.
    CS = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1, 1'b0);
    CS = 1'b1;
    repeat (4) @(negedge clk);
    m_err = 1;
    send_byte(0, 8'h11);
    chk("slpout_byte", BYTE, 8'h11);
    check_flags("partial");
    check_stream("partial");
    // Panel reset mid-RAMWR with a non-default window and half a pixel pending.
    send_cmd4(8'h2A, 8'h00, 8'h03, 8'h00, 8'h06);
    send_byte(0, 8'h2C);
    send_byte(1, 8'h12); send_byte(1, 8'h34); send_byte(1, 8'h56);
    check_stream("pre_lcd_reset");
    LCD_RESET_N = 1'b0;
    repeat (4) @(negedge clk);
    chk("lcd_reset_outputs", {BYTE_VALID, BYTE, BYTE_DC, PIX_VALID, PIX_X, PIX_Y, PIX_DATA, DISP_ON, SLEEP_OUT, PROTO_ERR}, 64'd0);
    LCD_RESET_N = 1'b1;
    repeat (4) @(negedge clk);
    m_reset();
    send_byte(0, 8'h2C);
    send_byte(1, 8'hF8); send_byte(1, 8'h00);
    chk("post_reset_pixel", PIX_DATA, 16'hF800);
    chk("post_reset_xy", {PIX_X, PIX_Y}, 16'h0000);
    check_stream("lcd_reset");
    // SWRESET restores defaults and clears both flags.
    send_byte(0, 8'h29); send_byte(0, 8'h11);
    send_cmd4(8'h2A, 8'h00, 8'h10, 8'h00, 8'h20);
    send_byte(0, 8'h01);
    chk("swreset_flags", {DISP_ON, SLEEP_OUT}, 2'b00);
    send_byte(0, 8'h2C);
    send_byte(1, 8'hF8); send_byte(1, 8'h00);
    chk("swreset_xy", {PIX_X, PIX_Y}, 16'h0000);
    check_stream("swreset");
    check_flags("swreset");
    // Command aborting a CASET after two arguments.
    send_byte(0, 8'h2A); send_byte(1, 8'h00); send_byte(1, 8'h07);
    send_byte(0, 8'h29);
    check_flags("abort");
    check_stream("abort");
    for (int it = 0; it < 6; it++) begin
      case ($urandom_range(0, 2))
        0: c = 8'h11;
        1: c = 8'h29;
        default: c = 8'h28;
      endcase
      send_byte(0, c);
      xs = 8'($urandom_range(0, 20)); xe = xs + 8'($urandom_range(0, 4));
      ys = 8'($urandom_range(0, 30)); ye = ys + 8'($urandom_range(0, 3));
      send_cmd4(8'h2A, 8'($urandom), xs, 8'($urandom), xe);
      send_cmd4(8'h2B, 8'($urandom), ys, 8'($urandom), ye);
      send_byte(0, 8'h2C);
      np = $urandom_range(1, (xe - xs + 1) * (ye - ys + 1) + 3);
      for (int p = 0; p < 2 * np; p++) send_byte(1, 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin CS = 1'b1; repeat (4) @(negedge clk); end
      check_stream($sformatf("rand%0d", it));
      check_flags($sformatf("rand%0d", it));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
